fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the write port of the team's synchronous FIFO among `N_REQ` producers. Tracks FIFO occupancy with its own credit counter, so it never issues a write that the FIFO would drop as overflow. Drives `wr_en`/`data_in` of the FIFO from registers and returns a one-cycle grant to the winning producer. Sits between the producer agents and the FIFO `data_in`/`wr_en` pins; the FIFO read side is untouched except for a pop indication fed back here.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 88 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-side arbiter.
// Default sizing plus credit counter width derivation.
package fifo_arb_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_width(FIFO_DEPTH_DEF);

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible index above last.
// Purely combinational; the caller owns the last register.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan upward from last+1, wrapping, take the first hit
  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!any && elig[c]) begin
        any       = 1'b1;
        idx       = IW'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the sync FIFO.
// Issues writes only against credits so the FIFO never overflows.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_pop,
  output logic [$clog2(FIFO_DEPTH):0] credits,
  output logic                        credit_err
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    last;
  logic             any;
  logic             issue;
  logic             pop_ok;

  // A producer whose grant is high is still updating its request
  assign eligible = req & ~gnt;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .elig   (eligible),
    .last   (last),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (any)
  );

  assign issue  = arb_en && (credits != '0) && any;
  // A pop with every slot free is bogus and is not credited
  assign pop_ok = fifo_pop && (credits != FULL);

  // Grant, write strobe, data and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      last         <= IW'(N_REQ - 1);
    end else if (issue) begin
      gnt          <= win_oh;
      fifo_wr_en   <= 1'b1;
      fifo_data_in <= req_data[win_idx*FIFO_WIDTH +: FIFO_WIDTH];
      last         <= win_idx;
    end else begin
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
    end
  end

  // Free-slot credit counter and sticky underflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= FULL;
      credit_err <= 1'b0;
    end else begin
      if (issue && !pop_ok) begin
        credits <= credits - CW'(1);
      end else if (!issue && pop_ok) begin
        credits <= credits + CW'(1);
      end
      if (fifo_pop && credits == FULL) begin
        credit_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, corner
// sequences and random traffic against a reference model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arb_en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_pop = 1'b0;
  logic [3:0]     credits;
  logic           credit_err;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arb_en       (arb_en),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_pop     (fifo_pop),
    .credits      (credits),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int           seq [N];
  logic [N-1:0] m_gnt;
  logic         m_wr;
  logic [W-1:0] m_data;
  int           m_cred;
  logic         m_err;
  int           m_last;

  typedef struct {
    logic [N-1:0] req;
    logic         pop;
    logic [N-1:0] gnt;
    int           cred;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [W-1:0] word(input int i);
    return W'(32'h1000 + i + (seq[i] << 4));
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_gnt  = '0;
    m_wr   = 1'b0;
    m_data = '0;
    m_cred = D;
    m_err  = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) seq[i] = 0;
  endtask

  task automatic do_reset();
    req      = '0;
    arb_en   = 1'b0;
    fifo_pop = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, predict, compare after posedge
  task automatic step(input logic [N-1:0] r,
                      input logic en,
                      input logic p);
    logic [N-1:0] el;
    int w;
    int c;
    bit iss;
    bit pv;
    req      = r;
    arb_en   = en;
    fifo_pop = p;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i);
    el = r & ~m_gnt;
    w  = -1;
    for (int off = 1; off <= N; off++) begin
      c = (m_last + off) % N;
      if (w < 0 && el[c]) w = c;
    end
    iss = en && (m_cred > 0) && (w >= 0);
    pv  = p && (m_cred != D);
    if (p && m_cred == D) m_err = 1'b1;
    m_cred = m_cred - (iss ? 1 : 0) + (pv ? 1 : 0);
    if (iss) begin
      m_gnt    = '0;
      m_gnt[w] = 1'b1;
      m_wr     = 1'b1;
      m_data   = word(w);
      m_last   = w;
      seq[w]++;
    end else begin
      m_gnt = '0;
      m_wr  = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
    chk("data_in", 32'(fifo_data_in), 32'(m_data));
    chk("credits", 32'(credits), 32'(m_cred));
    chk("credit_err", 32'(credit_err), 32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tbl[i].req  = 4'b1111;
      tbl[i].pop  = 1'b0;
      tbl[i].gnt  = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      tbl[i].cred = (i < 8) ? 7 - i : 0;
    end
    tbl[10] = '{req: 4'b0100, pop: 1'b1, gnt: 4'b0000, cred: 1};
    tbl[11] = '{req: 4'b0100, pop: 1'b0, gnt: 4'b0100, cred: 0};

    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr", 32'(fifo_wr_en), 32'h0);
    chk("rst_data", 32'(fifo_data_in), 32'h0);
    chk("rst_cred", 32'(credits), 32'd8);
    chk("rst_err", 32'(credit_err), 32'h0);

    // Fill the FIFO, then refill one slot for producer 2
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, 1'b1, tbl[i].pop);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_wr", i), 32'(fifo_wr_en),
          32'(|tbl[i].gnt));
      chk($sformatf("tbl%0d_cred", i), 32'(credits),
          32'(tbl[i].cred));
    end
    chk("p2_data", 32'(fifo_data_in), 32'h1022);

    // Lone producer: granted every other cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b0001, 1'b1, 1'b0);
      chk($sformatf("lone%0d", k), 32'(gnt[0]), 32'(k % 2 == 0));
    end
    chk("lone_cred", 32'(credits), 32'd4);

    // Issue and pop together at credits=3
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk($sformatf("bal%0d_cred", k), 32'(credits), 32'd3);
      chk($sformatf("bal%0d_wr", k), 32'(fifo_wr_en), 32'd1);
    end

    // Spurious pop at full credit
    do_reset();
    step(4'b0000, 1'b1, 1'b1);
    chk("err_set", 32'(credit_err), 32'd1);
    chk("err_cred", 32'(credits), 32'd8);
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b0);
    chk("err_sticky", 32'(credit_err), 32'd1);

    // arb_en low blocks new grants
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    chk("dis_gnt", 32'(gnt), 32'h0);

    // Asynchronous reset mid-stream
    do_reset();
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("pre_rst_wr", 32'(fifo_wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_wr", 32'(fifo_wr_en), 32'h0);
    chk("arst_data", 32'(fifo_data_in), 32'h0);
    chk("arst_cred", 32'(credits), 32'd8);
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 1'b0);
    chk("arst_first", 32'(gnt), 32'h1);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
